// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Sits behind the UART receiver and turns its byte stream into frames of the form
// SYNC, LEN, LEN payload bytes, CHK, where CHK is the XOR of LEN and every payload byte.
// Payload bytes are streamed out as soon as they arrive. The frame outcome is reported
// afterwards as a done pulse or as an error pulse with a code.
module uart_rx_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN   = 16,
    parameter logic [15:0] TIMEOUT   = 16'd2600
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] RxData,
    input  logic       RxDone,
    input  logic       Clear,
    output logic [7:0] PayloadData,
    output logic       PayloadValid,
    output logic [7:0] FrameLen,
    output logic       FrameDone,
    output logic       FrameErr,
    output logic [1:0] ErrCode,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GETLEN  = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } stateType;

    localparam logic [7:0]  MaxLenByte  = 8'(MAX_LEN);
    localparam logic [15:0] TimeoutLast = TIMEOUT - 16'd1;

    localparam logic [1:0] ErrBadLen   = 2'b01;
    localparam logic [1:0] ErrChecksum = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    stateType    state, stateNext;
    logic [7:0]  runXor, runXorNext;
    logic [7:0]  remainCount, remainCountNext;
    logic [15:0] timeoutCount, timeoutCountNext;

    logic [7:0]  payloadDataNext;
    logic        payloadValidNext;
    logic [7:0]  frameLenNext;
    logic        frameDoneNext;
    logic        frameErrNext;
    logic [1:0]  errCodeNext;

    // Busy is a direct decode of the state register, so it is registered as well
    assign Busy = (state != IDLE);

    // Register the state, the checksum/count/timeout datapath and every output
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state        <= IDLE;
            runXor       <= 8'h00;
            remainCount  <= 8'h00;
            timeoutCount <= 16'h0000;
            PayloadData  <= 8'h00;
            PayloadValid <= 1'b0;
            FrameLen     <= 8'h00;
            FrameDone    <= 1'b0;
            FrameErr     <= 1'b0;
            ErrCode      <= 2'b00;
        end else begin
            state        <= stateNext;
            runXor       <= runXorNext;
            remainCount  <= remainCountNext;
            timeoutCount <= timeoutCountNext;
            PayloadData  <= payloadDataNext;
            PayloadValid <= payloadValidNext;
            FrameLen     <= frameLenNext;
            FrameDone    <= frameDoneNext;
            FrameErr     <= frameErrNext;
            ErrCode      <= errCodeNext;
        end
    end

    // Next state and next outputs; Clear beats a received byte, which beats the timeout
    always_comb begin
        stateNext        = state;
        runXorNext       = runXor;
        remainCountNext  = remainCount;
        timeoutCountNext = timeoutCount;
        payloadDataNext  = PayloadData;
        payloadValidNext = 1'b0;
        frameLenNext     = FrameLen;
        frameDoneNext    = 1'b0;
        frameErrNext     = 1'b0;
        errCodeNext      = ErrCode;

        if (Clear) begin
            stateNext        = IDLE;
            runXorNext       = 8'h00;
            remainCountNext  = 8'h00;
            timeoutCountNext = 16'h0000;
        end else if (RxDone) begin
            timeoutCountNext = 16'h0000;
            case (state)
                IDLE: begin
                    if (RxData == SYNC_BYTE) begin
                        stateNext = GETLEN;
                    end
                end
                GETLEN: begin
                    if ((RxData == 8'h00) || (RxData > MaxLenByte)) begin
                        frameErrNext = 1'b1;
                        errCodeNext  = ErrBadLen;
                        stateNext    = IDLE;
                    end else begin
                        frameLenNext    = RxData;
                        runXorNext      = RxData;
                        remainCountNext = RxData;
                        stateNext       = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    payloadDataNext  = RxData;
                    payloadValidNext = 1'b1;
                    runXorNext       = runXor ^ RxData;
                    remainCountNext  = remainCount - 8'd1;
                    if (remainCount == 8'd1) begin
                        stateNext = CHECK;
                    end
                end
                CHECK: begin
                    if (RxData == runXor) begin
                        frameDoneNext = 1'b1;
                    end else begin
                        frameErrNext = 1'b1;
                        errCodeNext  = ErrChecksum;
                    end
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            if (timeoutCount == TimeoutLast) begin
                frameErrNext     = 1'b1;
                errCodeNext      = ErrTimeout;
                stateNext        = IDLE;
                timeoutCountNext = 16'h0000;
            end else begin
                timeoutCountNext = timeoutCount + 16'd1;
            end
        end
    end

endmodule

// File: doc/uart_rx_frame_parser.md
# uart_rx_frame_parser

Byte-stream frame parser sitting directly downstream of the UART receiver. Consumes the receiver's `RxData`/`RxDone` byte stream, hunts for a sync byte, and extracts length-prefixed payloads. Validates each frame with an XOR checksum and an inter-byte timeout. Streams payload bytes to user logic and reports each frame's outcome as either a done pulse or an error pulse with a code.

## Interface
- `SYNC_BYTE`, 8'hA5, frame start marker
- `MAX_LEN`, 16, largest legal payload length (1..255)
- `TIMEOUT`, 16'd2600, max clock cycles allowed between bytes inside a frame (≥2)
- `Clk` in 1, system clock
- `Rst_n` in 1, reset, asynchronous, active-low
- `RxData` in 8, received byte from UART receiver, valid when `RxDone`=1
- `RxDone` in 1, one-cycle pulse per received byte
- `Clear` in 1, synchronous abort: return to IDLE, no status pulse
- `PayloadData` out 8, current payload byte
- `PayloadValid` out 1, one-cycle pulse per payload byte
- `FrameLen` out 8, LEN field of current/last frame
- `FrameDone` out 1, one-cycle pulse, frame checksum correct
- `FrameErr` out 1, one-cycle pulse, frame aborted
- `ErrCode` out 2, valid with `FrameErr`: 01 bad length, 10 checksum mismatch, 11 timeout
- `Busy` out 1, high whenever state ≠ IDLE

## Operation
- Frame format: SYNC, LEN, LEN payload bytes, CHK; CHK = LEN ^ P0 ^ … ^ P(LEN-1).
- States: IDLE, GETLEN, PAYLOAD, CHECK. All transitions occur only on a sampled `RxDone`, except timeout and `Clear`.
- IDLE: byte == SYNC_BYTE → GETLEN, clear timeout counter. Any other byte is dropped silently.
- GETLEN: LEN in 1..MAX_LEN → store in `FrameLen`, load running XOR = LEN, load remaining count = LEN, → PAYLOAD. LEN=0 or LEN>MAX_LEN → `FrameErr`, ErrCode 01, → IDLE. The offending byte is never re-examined as a sync byte.
- PAYLOAD: drive byte on `PayloadData`, pulse `PayloadValid`, XOR byte into the running value, decrement remaining count. When the count reaches 0 → CHECK. A payload byte equal to SYNC_BYTE is plain data.
- CHECK: byte == running XOR → `FrameDone`; otherwise `FrameErr` with ErrCode 10. Either way → IDLE.
- Payload is streamed before validation; the consumer discards it on `FrameErr`.
- Timeout counter (16 bit) runs only outside IDLE. It clears on every sampled `RxDone` and increments on every other edge. When the next increment would equal TIMEOUT: `FrameErr`, ErrCode 11, → IDLE.
- `Clear`=1: → IDLE, counters zeroed, no pulse. `FrameLen` is held.
- Priority, highest first: `Clear` > `RxDone` > timeout. A byte arriving on the timeout edge is accepted and the counter resets. A byte arriving with `Clear` is dropped.
- `FrameDone` and `FrameErr` are never high together. `ErrCode` holds its last value between errors.

## Timing
- Reset values: state IDLE, `PayloadData`=0, `PayloadValid`=0, `FrameLen`=0, `FrameDone`=0, `FrameErr`=0, `ErrCode`=00, `Busy`=0, counters 0.
- All outputs are registered. Latency is 1 cycle: pulses appear in the cycle after the cycle where `RxDone`=1 was sampled.
- `Busy` rises 1 cycle after the SYNC byte's `RxDone`. It falls in the same cycle as the terminating `FrameDone` or `FrameErr` pulse, or 1 cycle after `Clear`.
- Timeout: `FrameErr` is registered at the TIMEOUT-th rising edge after the edge that sampled the last `RxDone`.
- Back-to-back `RxDone` on consecutive cycles must be handled with no loss. A new SYNC may be sampled on the same edge that produced `FrameDone` or `FrameErr`.
- Reset asserted mid-frame: all outputs drop immediately to their reset values, with no pulses emitted.

## Test plan
- Good frame: A5 03 11 22 33 03 → `PayloadValid` ×3 carrying 11, 22, 33; `FrameLen`=3; one `FrameDone`; `Busy` 1→0.
- Bad checksum: A5 02 AA 55 00 (expected CHK FD) → 2 payload pulses, then `FrameErr` with ErrCode 10, no `FrameDone`.
- Hunt and length errors: 00 FF dropped with no outputs. A5 00 → ErrCode 01. A5 11 (17 > 16) → ErrCode 01. A following 11 is ignored.
- Timeout (TIMEOUT=50): A5 04 01, then silence → `FrameErr` ErrCode 11 exactly 50 edges after the 01 byte's sample. Then A5 01 A5 A4 → payload A5, `FrameDone`. A byte arriving exactly on edge 50 → no error.
- Back-to-back bytes, with `RxDone` on consecutive cycles: A5 01 7E 7F → payload 7E, `FrameDone`. Next frame's A5 is sampled on the `FrameDone` edge and still parsed.
- Abort: `Clear` in mid-payload, same cycle as `RxDone` → byte dropped, `Busy`=0, no pulses. `Rst_n` low mid-frame → outputs reset asynchronously; the next full frame parses correctly.
